mem_loader: RTL
===============

MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 4096, processor memory size in bytes.
REQ-002 SHALL have parameter ADDR_W, default 12, byte address width (log2 MEM_BYTES).
REQ-003 SHALL have parameter CNT_W, default 11, word counter width (holds MEM_BYTES/4).
REQ-004 SHALL have port Clk, input, 1, single clock; all state changes on rising edge.
REQ-005 SHALL have port Reset, input, 1; reset is asynchronous and active-high.
REQ-006 SHALL have port Start, input, 1, one-cycle request to begin a program load.
REQ-007 SHALL have port Num_words, input, CNT_W, number of 32-bit words to load, sampled on accepted Start.
REQ-008 SHALL have port Word_valid, input, 1, source presents a program word.
REQ-009 SHALL have port Word_data, input, 32, program word.
REQ-010 SHALL have port Word_ready, output, 1, loader accepts a word this cycle.
REQ-011 SHALL have port Mem_we, output, 1, byte write strobe to processor memory.
REQ-012 SHALL have port Mem_addr, output, ADDR_W, byte write address.
REQ-013 SHALL have port Mem_wdata, output, 8, byte write data.
REQ-014 SHALL have port Cpu_reset, output, 1, holds the processor in reset while not loaded.
REQ-015 SHALL have port Done, output, 1, load complete.
REQ-016 SHALL have port Error, output, 1, Num_words exceeded MEM_BYTES/4.
REQ-017 SHALL have port Words_loaded, output, CNT_W, count of words fully written.

Function
REQ-018 SHALL implement states IDLE, WAIT_WORD, WRITE, DONE, ERR; all outputs registered.
REQ-019 SHALL, in IDLE, on Start: Num_words=0 -> DONE; Num_words>MEM_BYTES/4 -> ERR; else -> WAIT_WORD, base address 0, Words_loaded 0.
REQ-020 SHALL drive Word_ready=1 only in WAIT_WORD; handshake completes when Word_valid and Word_ready both high at a rising edge.
REQ-021 SHALL latch Word_data on handshake and enter WRITE with byte index 0; Word_ready low the next cycle.
REQ-022 SHALL, in WRITE, issue 4 consecutive cycles with Mem_we=1, Mem_addr=4*Words_loaded+idx, Mem_wdata=word[8*idx+:8], idx 0..3 (little-endian: byte 0 at lowest address).
REQ-023 SHALL give first Mem_we the cycle after handshake; sustained throughput one word per 5 cycles.
REQ-024 SHALL, after idx 3, increment Words_loaded; if equal to latched Num_words -> DONE, else -> WAIT_WORD.
REQ-025 SHALL drive Cpu_reset=1 in every state except DONE; Done=1 only in DONE; Error=1 only in ERR.
REQ-026 SHALL ignore Start in WAIT_WORD and WRITE; Start in DONE or ERR restarts per REQ-019 (Cpu_reset reasserts the next cycle).
REQ-027 SHALL ignore Word_valid outside WAIT_WORD; data not consumed remains the source's responsibility.
REQ-028 SHALL never wrap Mem_addr; REQ-019 guarantees highest address MEM_BYTES-1.

Reset
REQ-029 SHALL, on Reset asserted (any cycle, mid-write included), immediately enter IDLE: Word_ready=0, Mem_we=0, Mem_addr=0, Mem_wdata=0, Cpu_reset=1, Done=0, Error=0, Words_loaded=0.
REQ-030 SHALL resume operation on the first rising edge after Reset deasserts; partial writes are not completed.

Structure
REQ-031 SHALL place state encoding, MEM_BYTES default, and byte-per-word constant (4) in a shared package.
REQ-032 SHALL be a single module with no sub-module; the memory array stays in the processor.

Verification
REQ-033 SHALL check: Start, Num_words=2, words 0x11223344, 0xAABBCCDD back-to-back -> addresses 0..7 get 44,33,22,11,DD,CC,BB,AA; Done=1, Cpu_reset=0, Words_loaded=2.
REQ-034 SHALL check: Num_words=0 -> DONE one cycle after Start, no Mem_we pulses.
REQ-035 SHALL check: Num_words=1025 -> Error=1, Cpu_reset=1, no Mem_we, Word_ready stays 0.
REQ-036 SHALL check: Word_valid toggled randomly with Num_words=3 -> exactly 12 Mem_we pulses, correct bytes, no word lost or duplicated.
REQ-037 SHALL check: Reset asserted during byte 2 of word 1 -> all outputs at reset values asynchronously; new Start, Num_words=1, 0xDEADBEEF -> bytes EF,BE,AD,DE at addresses 0..3.
REQ-038 SHALL check: Num_words=1024 full load -> last write at address 0xFFF, Words_loaded=1024, Done=1.

Source files
------------

// File: rtl/mem_loader_pkg.sv
// Shared definitions for the program loader: state encoding, memory size
// default and word/byte geometry.
package mem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_WORD = 3'd1,
    S_WRITE     = 3'd2,
    S_DONE      = 3'd3,
    S_ERR       = 3'd4
  } state_t;

  localparam int MEM_BYTES_DEFAULT = 4096;
  localparam int WORD_BYTES        = 4;

  // Little-endian byte lane of a 32-bit word (lane 0 = bits 7:0).
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] i);
    return w[{i, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/mem_loader.sv
// Program loader: accepts 32-bit words over a valid/ready handshake and
// writes them byte by byte into processor memory, holding the processor in
// reset until the requested number of words has been written.
//
// state       | meaning
// ------------+--------------------------------------------------------
// S_IDLE      | after reset, waiting for Start
// S_WAIT_WORD | Word_ready high, waiting for the source to present a word
// S_WRITE     | emitting the 4 bytes of the latched word, one per cycle
// S_DONE      | load complete, processor released from reset
// S_ERR       | requested word count does not fit in memory
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEFAULT,
  parameter int ADDR_W    = 12,
  parameter int CNT_W     = 11
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [CNT_W-1:0]  Num_words,
  input  logic              Word_valid,
  input  logic [31:0]       Word_data,
  output logic              Word_ready,
  output logic              Mem_we,
  output logic [ADDR_W-1:0] Mem_addr,
  output logic [7:0]        Mem_wdata,
  output logic              Cpu_reset,
  output logic              Done,
  output logic              Error,
  output logic [CNT_W-1:0]  Words_loaded
);

  localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(MEM_BYTES / WORD_BYTES);

  state_t            state, state_n;
  logic [1:0]        idx, idx_n;
  logic [31:0]       word, word_n;
  logic [CNT_W-1:0]  num, num_n;
  logic [CNT_W-1:0]  wl_n;
  logic [ADDR_W-1:0] addr_n;
  logic [7:0]        wdata_n;

  // Next-state and next-output computation; outputs are registered from
  // the next state so every output is a flop.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    word_n  = word;
    num_n   = num;
    wl_n    = Words_loaded;
    addr_n  = Mem_addr;
    wdata_n = Mem_wdata;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (Start) begin
          num_n = Num_words;
          wl_n  = '0;
          idx_n = 2'd0;
          if (Num_words == '0)            state_n = S_DONE;
          else if (Num_words > MAX_WORDS) state_n = S_ERR;
          else                            state_n = S_WAIT_WORD;
        end
      end
      S_WAIT_WORD: begin
        // Word_ready is registered high in this state, so valid alone
        // completes the handshake.
        if (Word_valid) begin
          word_n  = Word_data;
          idx_n   = 2'd0;
          state_n = S_WRITE;
        end
      end
      S_WRITE: begin
        if (idx == 2'd3) begin
          wl_n    = Words_loaded + CNT_W'(1);
          state_n = (wl_n == num) ? S_DONE : S_WAIT_WORD;
        end else begin
          idx_n = idx + 2'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase
    // Word count never exceeds MEM_BYTES/4 here, so the address cannot wrap.
    if (state_n == S_WRITE) begin
      addr_n  = {wl_n[ADDR_W-3:0], idx_n};
      wdata_n = word_byte(word_n, idx_n);
    end
  end

  // State and registered outputs; Reset aborts any write in progress.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= S_IDLE;
      idx          <= 2'd0;
      word         <= '0;
      num          <= '0;
      Words_loaded <= '0;
      Word_ready   <= 1'b0;
      Mem_we       <= 1'b0;
      Mem_addr     <= '0;
      Mem_wdata    <= '0;
      Cpu_reset    <= 1'b1;
      Done         <= 1'b0;
      Error        <= 1'b0;
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      word         <= word_n;
      num          <= num_n;
      Words_loaded <= wl_n;
      Word_ready   <= (state_n == S_WAIT_WORD);
      Mem_we       <= (state_n == S_WRITE);
      Mem_addr     <= addr_n;
      Mem_wdata    <= wdata_n;
      Cpu_reset    <= (state_n != S_DONE);
      Done         <= (state_n == S_DONE);
      Error        <= (state_n == S_ERR);
    end
  end

endmodule
